// File: rtl/pendulum_pkg.sv
// Shared constants for the pendulum angle normaliser: fp32 field widths,
// the pi constants and the normaliser FSM state encoding.
package pendulum_pkg;

    localparam int FP_W  = 32;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;

    localparam logic [FP_W-1:0] PI     = 32'h40490FDB;
    localparam logic [FP_W-1:0] TWO_PI = 32'h40C90FDB;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CHECK = 2'd1;
    localparam logic [1:0] ST_ADJ   = 2'd2;
    localparam logic [1:0] ST_OUT   = 2'd3;

endpackage

// File: rtl/fp32_addsub.sv
// Pipelined IEEE-754 single-precision add/subtract: round to nearest-even,
// denormal operands and results flushed to zero, ADD_LAT enabled cycles deep.
module fp32_addsub
    import pendulum_pkg::*;
#(
    parameter int ADD_LAT = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ena,
    input  logic            op_sub,
    input  logic [FP_W-1:0] a,
    input  logic [FP_W-1:0] b,
    output logic [FP_W-1:0] result
);

    function automatic logic [FP_W-1:0] round_pack(input logic sgn,
                                                   input logic signed [10:0] exp_in,
                                                   input logic [26:0] frac);
        logic               up;
        logic [24:0]        mant;
        logic signed [10:0] e;
        e    = exp_in;
        up   = frac[2] & (frac[1] | frac[0] | frac[3]);
        mant = {1'b0, frac[26:3]} + {24'd0, up};
        if (mant[24]) begin
            mant = mant >> 1;
            e    = e + 11'sd1;
        end
        if (e <= 11'sd0)   return {sgn, 31'd0};
        if (e >= 11'sd255) return {sgn, 8'hFF, 23'd0};
        return {sgn, e[7:0], mant[22:0]};
    endfunction

    function automatic logic [FP_W-1:0] fp_add(input logic [FP_W-1:0] x,
                                               input logic [FP_W-1:0] y);
        logic [FP_W-1:0]    big;
        logic [FP_W-1:0]    sml;
        logic [EXP_W-1:0]   d;
        logic [26:0]        fb;
        logic [26:0]        fs;
        logic [27:0]        sum;
        logic signed [10:0] e;
        logic [4:0]         lz;
        if (x[30:23] == 8'hFF) return x;
        if (y[30:23] == 8'hFF) return y;
        if (x[30:23] == 8'h00 && y[30:23] == 8'h00) return {x[31] & y[31], 31'd0};
        if (x[30:23] == 8'h00) return y;
        if (y[30:23] == 8'h00) return x;
        if (x[30:0] >= y[30:0]) begin
            big = x;
            sml = y;
        end else begin
            big = y;
            sml = x;
        end
        d  = big[30:23] - sml[30:23];
        fb = {1'b1, big[22:0], 3'b000};
        fs = {1'b1, sml[22:0], 3'b000};
        // Alignment keeps guard/round bits and ORs everything shifted out into sticky
        if (d >= 8'd27) fs = 27'd1;
        else            fs = (fs >> d) | {26'd0, |(fs & ((27'd1 << d) - 27'd1))};
        e = signed'({3'b000, big[30:23]});
        if (big[31] == sml[31]) begin
            sum = {1'b0, fb} + {1'b0, fs};
            if (sum[27]) begin
                sum = {1'b0, sum[27:2], sum[1] | sum[0]};
                e   = e + 11'sd1;
            end
        end else begin
            sum = {1'b0, fb} - {1'b0, fs};
            if (sum == 28'd0) return 32'd0;
            lz = 5'd0;
            for (int i = 0; i < 27; i++) if (sum[i]) lz = 5'(26 - i);
            sum = sum << lz;
            e   = e - signed'({6'd0, lz});
        end
        return round_pack(big[31], e, sum[26:0]);
    endfunction

    logic [FP_W-1:0] w_b;
    logic [FP_W-1:0] w_res_p0;
    logic [FP_W-1:0] r_sum_p [ADD_LAT];

    assign w_b      = {b[FP_W-1] ^ op_sub, b[FP_W-2:0]};
    assign w_res_p0 = fp_add(a, w_b);

    // Stage boundary: result travels ADD_LAT registers, frozen while ena is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ADD_LAT; i++) r_sum_p[i] <= '0;
        end else if (ena) begin
            r_sum_p[0] <= w_res_p0;
            for (int i = 1; i < ADD_LAT; i++) r_sum_p[i] <= r_sum_p[i-1];
        end
    end

    assign result = r_sum_p[ADD_LAT-1];

endmodule

// File: rtl/pendulum_angle_norm.sv
// Wraps a pendulum angle into [-pi, pi) by repeated +/-2pi corrections through
// a shared pipelined fp32 adder; velocity and torque ride along untouched.
module pendulum_angle_norm
    import pendulum_pkg::*;
#(
    parameter int ADD_LAT  = 3,
    parameter int MAX_ITER = 8
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_ena,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [FP_W-1:0] i_th,
    input  logic [FP_W-1:0] i_thdot,
    input  logic [FP_W-1:0] i_tor,
    output logic            o_valid,
    output logic [FP_W-1:0] o_th,
    output logic [FP_W-1:0] o_thdot,
    output logic [FP_W-1:0] o_tor,
    output logic            o_err
);

    localparam int CNT_W  = $clog2(MAX_ITER + 1);
    localparam int WAIT_W = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

    logic [1:0]       r_state;
    logic [FP_W-1:0]  r_x;
    logic [FP_W-1:0]  r_thdot;
    logic [FP_W-1:0]  r_tor;
    logic [CNT_W-1:0] r_cnt;
    logic [WAIT_W-1:0] r_wait;
    logic [FP_W-1:0]  r_o_th;
    logic [FP_W-1:0]  r_o_thdot;
    logic [FP_W-1:0]  r_o_tor;
    logic             r_o_err;

    logic             w_nan;
    logic             w_high;
    logic             w_low;
    logic             w_in;
    logic             w_ovf;
    logic [FP_W-1:0]  w_sum;

    // Range test on raw bits: -pi is in range, +pi is not
    assign w_nan  = (r_x[FP_W-2:MAN_W] == {EXP_W{1'b1}});
    assign w_high = !r_x[FP_W-1] && (r_x[FP_W-2:0] >= PI[FP_W-2:0]);
    assign w_low  =  r_x[FP_W-1] && (r_x[FP_W-2:0] >  PI[FP_W-2:0]);
    assign w_in   = !w_high && !w_low;
    assign w_ovf  = (r_cnt == CNT_W'(MAX_ITER));

    fp32_addsub #(
        .ADD_LAT (ADD_LAT)
    ) u_addsub (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .ena    (i_ena),
        .op_sub (w_high),
        .a      (r_x),
        .b      (TWO_PI),
        .result (w_sum)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_x       <= '0;
            r_thdot   <= '0;
            r_tor     <= '0;
            r_cnt     <= '0;
            r_wait    <= '0;
            r_o_th    <= '0;
            r_o_thdot <= '0;
            r_o_tor   <= '0;
            r_o_err   <= 1'b0;
        end else if (i_ena) begin
            case (r_state)
                ST_IDLE: begin
                    if (i_valid) begin
                        r_x     <= i_th;
                        r_thdot <= i_thdot;
                        r_tor   <= i_tor;
                        r_cnt   <= '0;
                        r_state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (w_nan || w_in || w_ovf) begin
                        r_o_th    <= r_x;
                        r_o_thdot <= r_thdot;
                        r_o_tor   <= r_tor;
                        r_o_err   <= w_nan || !w_in;
                        r_state   <= ST_OUT;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                        r_wait  <= '0;
                        r_state <= ST_ADJ;
                    end
                end
                ST_ADJ: begin
                    // Adder captured r_x at the CHECK edge; r_x is stable until the result lands
                    if (r_wait == WAIT_W'(ADD_LAT - 1)) begin
                        r_x     <= w_sum;
                        r_state <= ST_CHECK;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_ready = (r_state == ST_IDLE) && i_ena;
    assign o_valid = (r_state == ST_OUT);
    assign o_th    = r_o_th;
    assign o_thdot = r_o_thdot;
    assign o_tor   = r_o_tor;
    assign o_err   = r_o_err;

endmodule

// File: tb/tb_pendulum_angle_norm.sv
// Bench for pendulum_angle_norm: directed corner cases plus random angles,
// checked against a real-arithmetic wrap model.
module tb_pendulum_angle_norm;

    localparam int ADD_LAT  = 3;
    localparam int MAX_ITER = 8;
    localparam logic [31:0] PI_BITS  = 32'h40490FDB;
    localparam logic [31:0] TPI_BITS = 32'h40C90FDB;

    logic        i_clk   = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_ena   = 1'b0;
    logic        i_valid = 1'b0;
    logic [31:0] i_th    = '0;
    logic [31:0] i_thdot = '0;
    logic [31:0] i_tor   = '0;
    logic        o_ready;
    logic        o_valid;
    logic [31:0] o_th;
    logic [31:0] o_thdot;
    logic [31:0] o_tor;
    logic        o_err;

    int n_tests = 0;
    int n_fail  = 0;

    pendulum_angle_norm #(
        .ADD_LAT  (ADD_LAT),
        .MAX_ITER (MAX_ITER)
    ) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_ena   (i_ena),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_th    (i_th),
        .i_thdot (i_thdot),
        .i_tor   (i_tor),
        .o_valid (o_valid),
        .o_th    (o_th),
        .o_thdot (o_thdot),
        .o_tor   (o_tor),
        .o_err   (o_err)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic real f2r(input logic [31:0] f);
        logic [63:0] b;
        if (f[30:23] == 8'h00) return 0.0;
        b = {f[31], 11'({3'b000, f[30:23]}) + 11'd896, f[22:0], 29'd0};
        return $bitstoreal(b);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] b;
        logic [23:0] keep;
        logic [28:0] rem;
        logic        up;
        int          e;
        if (r == 0.0) return 32'd0;
        b    = $realtobits(r);
        keep = {1'b0, b[51:29]};
        rem  = b[28:0];
        up   = (rem > 29'h1000_0000) || (rem == 29'h1000_0000 && keep[0]);
        keep = keep + {23'd0, up};
        e    = int'(b[62:52]) - 1023 + 127;
        if (keep[23]) e++;
        return {b[63], 8'(e), keep[22:0]};
    endfunction

    // Wrap by +/-2pi in real arithmetic, rounding each step to fp32
    task automatic model(input logic [31:0] th, output logic [31:0] res,
                         output logic err, output int n);
        real v;
        n   = 0;
        err = 1'b0;
        res = th;
        if (th[30:23] == 8'hFF) begin
            err = 1'b1;
            return;
        end
        forever begin
            v = f2r(res);
            if (v >= -f2r(PI_BITS) && v < f2r(PI_BITS)) break;
            if (n == MAX_ITER) begin
                err = 1'b1;
                break;
            end
            res = r2f(v > 0.0 ? v - f2r(TPI_BITS) : v + f2r(TPI_BITS));
            n++;
        end
    endtask

    task automatic run_sample(input string tag, input logic [31:0] th,
                              input logic [31:0] thdot, input logic [31:0] tor,
                              input int stall_at, input int stall_len);
        logic [31:0] exp_th;
        logic        exp_err;
        int          n;
        int          lat;
        model(th, exp_th, exp_err, n);
        @(negedge i_clk);
        check({tag, ".ready"}, {31'd0, o_ready}, 32'd1);
        i_th    = th;
        i_thdot = thdot;
        i_tor   = tor;
        i_valid = 1'b1;
        @(posedge i_clk);
        lat = 0;
        while (lat < 300) begin
            @(negedge i_clk);
            lat++;
            i_th    = $urandom;
            i_thdot = $urandom;
            i_tor   = $urandom;
            if (stall_len > 0 && lat == stall_at) i_ena = 1'b0;
            if (stall_len > 0 && lat == stall_at + stall_len) i_ena = 1'b1;
            if (o_valid) break;
        end
        i_valid = 1'b0;
        i_ena   = 1'b1;
        check({tag, ".lat"}, 32'(lat), 32'(2 + n * (ADD_LAT + 1) + stall_len));
        check({tag, ".th"}, o_th, exp_th);
        check({tag, ".err"}, {31'd0, o_err}, {31'd0, exp_err});
        check({tag, ".thdot"}, o_thdot, thdot);
        check({tag, ".tor"}, o_tor, tor);
        @(negedge i_clk);
        check({tag, ".vld1cyc"}, {31'd0, o_valid}, 32'd0);
        check({tag, ".hold"}, o_th, exp_th);
    endtask

    initial begin
        logic seen;
        logic [31:0] th;
        #12;
        check("rst.valid", {31'd0, o_valid}, 32'd0);
        check("rst.err", {31'd0, o_err}, 32'd0);
        check("rst.th", o_th, 32'd0);
        check("rst.thdot", o_thdot, 32'd0);
        check("rst.tor", o_tor, 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        i_ena   = 1'b1;

        run_sample("one",    32'h3F800000, 32'h3F000000, 32'hBF800000, 0, 0);
        run_sample("four",   32'h40800000, 32'h40000000, 32'h41200000, 0, 0);
        run_sample("pi",     32'h40490FDB, 32'h11111111, 32'h22222222, 0, 0);
        run_sample("negpi",  32'hC0490FDB, 32'h33333333, 32'h44444444, 0, 0);
        run_sample("negz",   32'h80000000, 32'h55555555, 32'h66666666, 0, 0);
        run_sample("twenty", 32'h41A00000, 32'h77777777, 32'h88888888, 0, 0);
        run_sample("k1000",  32'h447A0000, 32'h99999999, 32'hAAAAAAAA, 0, 0);
        run_sample("nan",    32'h7FC00000, 32'hBBBBBBBB, 32'hCCCCCCCC, 0, 0);
        run_sample("ninf",   32'hFF800000, 32'hDDDDDDDD, 32'hEEEEEEEE, 0, 0);
        run_sample("stall",  32'h40800000, 32'h12345678, 32'h9ABCDEF0, 3, 5);

        // Reset in the middle of a correction
        @(negedge i_clk);
        i_th    = 32'h40800000;
        i_valid = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_valid = 1'b0;
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b0;
        #1;
        check("midrst.valid", {31'd0, o_valid}, 32'd0);
        check("midrst.th", o_th, 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check("midrst.ready", {31'd0, o_ready}, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge i_clk);
            if (o_valid) seen = 1'b1;
        end
        check("midrst.novalid", {31'd0, seen}, 32'd0);

        for (int k = 0; k < 12; k++) begin
            th = {1'($urandom_range(0, 1)), 8'($urandom_range(110, 134)), 23'($urandom)};
            if (k % 5 == 4) th = {th[31], 8'hFF, th[22:0]};
            run_sample($sformatf("rnd%0d", k), th, $urandom, $urandom, 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pendulum_angle_norm.md
PENDULUM_ANGLE_NORM -- requirements
Module: pendulum_angle_norm

Interface
REQ-001 SHALL provide parameter ADD_LAT, default 3: pipeline latency in cycles of the fp32 add/sub sub-module.
REQ-002 SHALL provide parameter MAX_ITER, default 8: maximum ±2π corrections per sample.
REQ-003 SHALL have the port i_clk  in  1: single clock; every register samples on its rising edge.
REQ-004 SHALL have the port i_rst_n  in  1: reset, asynchronous assert, active-low.
REQ-005 SHALL have the port i_ena  in  1: global enable; when low, all state, including the adder pipeline, holds.
REQ-006 SHALL have the port i_valid  in  1: input sample valid.
REQ-007 SHALL have the port o_ready  out  1: ready to accept a sample.
REQ-008 SHALL have the ports i_th, i_thdot, i_tor  in  32 each: IEEE-754 single-precision angle, angular velocity and torque.
REQ-009 SHALL have the port o_valid  out  1: one-cycle result strobe.
REQ-010 SHALL have the port o_th  out  32: angle normalised to [-π, π).
REQ-011 SHALL have the ports o_thdot, o_tor  out  32 each: i_thdot and i_tor as captured with the sample, unmodified.
REQ-012 SHALL have the port o_err  out  1: qualifies o_valid; set on NaN/Inf input or iteration overflow.

Function
REQ-013 SHALL accept a sample on a cycle where i_ena, i_valid and o_ready are all high, and SHALL capture all three operands and clear the iteration count.
REQ-014 SHALL assert o_ready only in state IDLE with i_ena high.
REQ-015 SHALL implement the states IDLE, CHECK, ADJ and OUT, with these transitions:
- IDLE→CHECK on accept.
- CHECK→OUT when the value is in range, is NaN/Inf, or the count equals MAX_ITER.
- CHECK→ADJ otherwise.
- ADJ→CHECK when the adder result returns after ADD_LAT enabled cycles.
- OUT→IDLE unconditionally.
REQ-016 SHALL perform the range test in CHECK combinationally on the raw bits, with PI=0x40490FDB:
- "high" when sign=0 and magnitude ≥ PI.
- "low" when sign=1 and magnitude > PI.
- In range otherwise; -0.0 is in range and -π is in range.
REQ-017 SHALL, in ADJ, issue x − 2π when the value is high and x + 2π when it is low, with TWO_PI=0x40C90FDB, and SHALL increment the count.
REQ-018 SHALL assert o_valid in OUT for exactly one cycle, with o_th, o_thdot, o_tor and o_err stable for that cycle; the outputs SHALL hold their values afterwards.
REQ-019 SHALL classify an exponent of 0xFF on i_th as NaN/Inf, go to OUT with o_err=1 and o_th=i_th, and perform no adjustment.
REQ-020 SHALL, on iteration overflow, set o_err=1 and give o_th the last unnormalised value.
REQ-021 SHALL have a latency from accept to o_valid of 2 + N·(ADD_LAT+1) enabled cycles, where N is the number of corrections; throughput SHALL be one sample per latency+1 cycles.
REQ-022 SHALL treat a low i_ena in any state as a stall: no transition, no counter change, and o_valid extended while held in OUT.
REQ-023 SHALL ignore i_valid while not in IDLE; no queueing.
REQ-024 SHALL make the adder round to nearest-even; denormal inputs SHALL be flushed to zero.

Reset
REQ-025 SHALL, while i_rst_n is low, force state=IDLE, o_valid=0, o_err=0, o_th=o_thdot=o_tor=0 and count=0, and clear the adder pipeline.
REQ-026 SHALL abort any sample in flight when reset is asserted mid-operation, never emit its result, and raise o_ready on the first enabled cycle after release.

Structure
REQ-027 SHALL place the PI and TWO_PI constants, the FSM state encoding and the fp32 field widths in the shared package pendulum_pkg.
REQ-028 SHALL instantiate a single sub-module, fp32_addsub, with ports clk, rst_n, ena, op_sub, a, b, result and latency ADD_LAT; it SHALL be reused by the dynamics stage.
REQ-029 SHALL connect o_th/o_thdot/o_tor/o_valid directly to i_th/i_thdot/i_tor/i_ena of the reward stage.

Verification
REQ-030 SHALL cover: i_th=0x3F800000 (1.0) → o_th=0x3F800000, o_err=0, o_valid 2 cycles after accept, o_thdot/o_tor pass-through.
REQ-031 SHALL cover: i_th=0x40800000 (4.0) → o_th ≈ -2.2831853 (±1 ULP), one correction, latency 2+(ADD_LAT+1)=6.
REQ-032 SHALL cover both boundaries:
- i_th=0x40490FDB (π) → o_th=0xC0490FDB (-π).
- i_th=0xC0490FDB (-π) → unchanged, latency 2.
REQ-033 SHALL cover: i_th=0x41A00000 (20.0) → o_th ≈ 1.1504440, three corrections, latency 14.
REQ-034 SHALL cover error cases:
- i_th=0x447A0000 (1000.0) → o_err=1 after MAX_ITER=8 corrections.
- i_th=0x7FC00000 (NaN) → o_err=1, latency 2.
REQ-035 SHALL cover control cases:
- i_rst_n pulsed low during ADJ → no o_valid for that sample; o_ready=1 after release.
- i_ena dropped for 5 cycles mid-ADJ → latency extended by exactly 5 cycles, result unchanged.
